// File: rtl/mc_control.sv
// -----------------------------------------------------------------------------
// mc_control -- multi-cycle MIPS-I main control unit.
//
// A Moore FSM steps each instruction through FETCH / DECODE / EXECUTE / MEM /
// WRITEBACK over a single shared memory port. mem_ready stretches the
// memory-facing states (FETCH, MEMRD, MEMWR) for variable-latency memory.
// Unknown opcodes either trap (illegal pulse, no architectural effect) or,
// when TRAP_ILLEGAL=0, execute as J for legacy compatibility. A free-running
// wrap-around counter tracks retired instructions.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   opcode         IR[31:26], sampled in DECODE
//   zero           ALU zero flag (used by the datapath with pc_write_cond)
//   mem_ready      memory completes the current access this cycle
//   pc_write       unconditional PC load
//   pc_write_cond  PC load if zero (BEQ)
//   iord           memory address select: 0 = PC, 1 = ALUOut
//   mem_read       memory read request
//   mem_write      memory write request
//   ir_write       instruction register load
//   mem_to_reg     write-back source: 1 = MDR
//   reg_dst        destination register: 1 = rd, 0 = rt
//   reg_write      register file write
//   alu_src_a      0 = PC, 1 = A
//   alu_src_b      00 = B, 01 = 4, 10 = sext imm, 11 = sext imm << 2
//   alu_op         00 add, 01 sub, 10 funct, 11 or
//   pc_src         00 = ALU, 01 = ALUOut, 10 = jump target
//   illegal        one-cycle pulse on an unknown opcode
//   retired        retired-instruction count (wraps)
//   state_o        current state encoding (debug)
// -----------------------------------------------------------------------------
module mc_control #(
  parameter int OPCODE_W     = 6,    // MIPS-I decode assumes exactly 6
  parameter int CNT_W        = 32,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_src,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired,
  output logic [3:0]          state_o
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTEXE  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_IMMEXE = 4'd10,
    S_IMMWB  = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(6'b001101);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);

  // Registered control word. 'fetch' marks FETCH so the two Mealy outputs
  // (ir_write, pc_write) can be qualified by mem_ready outside the register.
  typedef struct packed {
    logic       pc_write_u;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       fetch;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal;
  } ctl_t;

  state_t                r_state;
  state_t                w_next_state;
  ctl_t                  r_ctl;
  logic [OPCODE_W-1:0]   r_opcode;
  logic [CNT_W-1:0]      r_retired;
  logic                  w_retire;
  logic                  w_next_is_ori;
  logic                  w_unused;

  // The FSM only observes zero indirectly through pc_write_cond.
  assign w_unused = zero;

  // Control word for the state being entered. The ORI flag only matters for
  // IMMEXE, which is only ever entered from DECODE, so the live opcode at the
  // DECODE edge is the value that gets registered.
  function automatic ctl_t ctl_for(input state_t s, input logic is_ori);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.fetch     = 1'b1;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_RTEXE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_src        = 2'b01;
      end
      S_IMMEXE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = is_ori ? 2'b11 : 2'b00;
      end
      S_IMMWB: c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_write_u = 1'b1;
        c.pc_src     = 2'b10;
      end
      S_TRAP:  c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_IDLE:   w_next_state = S_FETCH;
      S_FETCH:  w_next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode == OP_RTYPE)
          w_next_state = S_RTEXE;
        else if (opcode == OP_LW || opcode == OP_SW)
          w_next_state = S_MEMADR;
        else if (opcode == OP_BEQ)
          w_next_state = S_BEQ;
        else if (opcode == OP_ADDI || opcode == OP_ORI)
          w_next_state = S_IMMEXE;
        else if (opcode == OP_J)
          w_next_state = S_JUMP;
        else
          w_next_state = TRAP_ILLEGAL ? S_TRAP : S_JUMP;
      end
      // Only LW/SW reach MEMADR, so anything but LW is treated as a store.
      S_MEMADR: w_next_state = (r_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_RTEXE:  w_next_state = S_ALUWB;
      S_IMMEXE: w_next_state = S_IMMWB;
      default:  w_next_state = S_FETCH;  // writeback states, TRAP, codes 14/15
    endcase
  end

  assign w_next_is_ori = (opcode == OP_ORI);

  // An instruction retires on the final cycle of its sequence; TRAP never does.
  assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                    (r_state == S_BEQ)   || (r_state == S_IMMWB) ||
                    (r_state == S_JUMP)  ||
                    ((r_state == S_MEMWR) && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ctl     <= '0;
      r_opcode  <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next_state;
      r_ctl   <= ctl_for(w_next_state, w_next_is_ori);
      if (r_state == S_DECODE)
        r_opcode <= opcode;
      if (w_retire)
        r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign pc_write      = r_ctl.pc_write_u | (r_ctl.fetch & mem_ready);
  assign ir_write      = r_ctl.fetch & mem_ready;
  assign pc_write_cond = r_ctl.pc_write_cond;
  assign iord          = r_ctl.iord;
  assign mem_read      = r_ctl.mem_read;
  assign mem_write     = r_ctl.mem_write;
  assign mem_to_reg    = r_ctl.mem_to_reg;
  assign reg_dst       = r_ctl.reg_dst;
  assign reg_write     = r_ctl.reg_write;
  assign alu_src_a     = r_ctl.alu_src_a;
  assign alu_src_b     = r_ctl.alu_src_b;
  assign alu_op        = r_ctl.alu_op;
  assign pc_src        = r_ctl.pc_src;
  assign illegal       = r_ctl.illegal;
  assign retired       = r_retired;
  assign state_o       = r_state;

endmodule

// File: tb/tb_mc_control.sv
// -----------------------------------------------------------------------------
// tb_mc_control -- self-checking bench for mc_control.
//
// Two instances share clock, reset and inputs: dut (TRAP_ILLEGAL=1, 32-bit
// counter) and dut_j (TRAP_ILLEGAL=0, 3-bit counter so wrap-around is reachable).
// The reference model expands each instruction into its expected per-cycle
// state list from the instruction class and the chosen wait counts, and holds
// the retired count as a plain integer.
// -----------------------------------------------------------------------------
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [31:0] retired;
  logic [3:0] state_o;

  logic pc_write_j, pc_write_cond_j, iord_j, mem_read_j, mem_write_j, ir_write_j;
  logic mem_to_reg_j, reg_dst_j, reg_write_j, alu_src_a_j, illegal_j;
  logic [1:0] alu_src_b_j, alu_op_j, pc_src_j;
  logic [2:0] retired_j;
  logic [3:0] state_o_j;

  int n_vec = 0;
  int n_bad = 0;
  int unsigned exp_ret = 0;

  always #5 clk = ~clk;

  mc_control #(.OPCODE_W(6), .CNT_W(32), .TRAP_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .illegal(illegal), .retired(retired), .state_o(state_o)
  );

  mc_control #(.OPCODE_W(6), .CNT_W(3), .TRAP_ILLEGAL(1'b0)) dut_j (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write_j), .pc_write_cond(pc_write_cond_j), .iord(iord_j),
    .mem_read(mem_read_j), .mem_write(mem_write_j), .ir_write(ir_write_j),
    .mem_to_reg(mem_to_reg_j), .reg_dst(reg_dst_j), .reg_write(reg_write_j),
    .alu_src_a(alu_src_a_j), .alu_src_b(alu_src_b_j), .alu_op(alu_op_j),
    .pc_src(pc_src_j), .illegal(illegal_j), .retired(retired_j), .state_o(state_o_j)
  );

  // Output vector order:
  // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
  //  reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal}
  function automatic logic [16:0] obs(input bit legacy);
    if (legacy)
      return {pc_write_j, pc_write_cond_j, iord_j, mem_read_j, mem_write_j,
              ir_write_j, mem_to_reg_j, reg_dst_j, reg_write_j, alu_src_a_j,
              alu_src_b_j, alu_op_j, pc_src_j, illegal_j};
    return {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
            pc_src, illegal};
  endfunction

  // Control outputs required in each named state.
  function automatic logic [16:0] exp_vec(input int st, input bit ori, input bit rdy);
    logic pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, ill;
    logic [1:0] sb, op, ps;
    {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, ill} = '0;
    sb = 2'b00; op = 2'b00; ps = 2'b00;
    case (st)
      1:  begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
      2:  sb = 2'b11;
      3:  begin sa = 1; sb = 2'b10; end
      4:  begin mr = 1; io = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin mw = 1; io = 1; end
      7:  begin sa = 1; op = 2'b10; end
      8:  begin rw = 1; rd = 1; end
      9:  begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
      10: begin sa = 1; sb = 2'b10; op = ori ? 2'b11 : 2'b00; end
      11: rw = 1;
      12: begin pw = 1; ps = 2'b10; end
      13: ill = 1;
      default: ;
    endcase
    return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps, ill};
  endfunction

  // Instruction class: 0 R, 1 LW, 2 SW, 3 BEQ, 4 ADDI/ORI, 5 J, 6 unknown
  function automatic int classify(input logic [5:0] opc);
    case (opc)
      6'b000000: return 0;
      6'b100011: return 1;
      6'b101011: return 2;
      6'b000100: return 3;
      6'b001000, 6'b001101: return 4;
      6'b000010: return 5;
      default: return 6;
    endcase
  endfunction

  // Runs one instruction starting in FETCH, checking every cycle. Returns
  // early (mid-cycle, after the checks) at cycle index abort_at if >= 0.
  task automatic run_instr(input logic [5:0] opc, input int fetch_wait,
                           input int mem_wait, input bit legacy, input int abort_at);
    int st_q[$];
    bit rdy_q[$];
    int cls;
    bit ori;
    bit retire;
    logic [16:0] ev, ov;
    logic [3:0] os;
    logic [31:0] orr, er;
    cls = classify(opc);
    ori = (opc == 6'b001101);
    retire = !(cls == 6 && !legacy);
    for (int w = 0; w < fetch_wait; w++) begin st_q.push_back(1); rdy_q.push_back(1'b0); end
    st_q.push_back(1); rdy_q.push_back(1'b1);
    st_q.push_back(2); rdy_q.push_back(1'($urandom));
    case (cls)
      0: begin
        st_q.push_back(7); rdy_q.push_back(1'($urandom));
        st_q.push_back(8); rdy_q.push_back(1'($urandom));
      end
      1: begin
        st_q.push_back(3); rdy_q.push_back(1'($urandom));
        for (int w = 0; w < mem_wait; w++) begin st_q.push_back(4); rdy_q.push_back(1'b0); end
        st_q.push_back(4); rdy_q.push_back(1'b1);
        st_q.push_back(5); rdy_q.push_back(1'($urandom));
      end
      2: begin
        st_q.push_back(3); rdy_q.push_back(1'($urandom));
        for (int w = 0; w < mem_wait; w++) begin st_q.push_back(6); rdy_q.push_back(1'b0); end
        st_q.push_back(6); rdy_q.push_back(1'b1);
      end
      3: begin st_q.push_back(9); rdy_q.push_back(1'($urandom)); end
      4: begin
        st_q.push_back(10); rdy_q.push_back(1'($urandom));
        st_q.push_back(11); rdy_q.push_back(1'($urandom));
      end
      5: begin st_q.push_back(12); rdy_q.push_back(1'($urandom)); end
      default: begin st_q.push_back(legacy ? 12 : 13); rdy_q.push_back(1'($urandom)); end
    endcase
    for (int i = 0; i < st_q.size(); i++) begin
      @(negedge clk);
      mem_ready = rdy_q[i];
      opcode = (st_q[i] == 2) ? opc : 6'($urandom);
      zero = 1'($urandom);
      #1;
      os = legacy ? state_o_j : state_o;
      n_vec++;
      if (os !== 4'(st_q[i])) begin
        n_bad++;
        $display("FAIL state op=%b legacy=%0d cyc=%0d got=%0d want=%0d", opc, legacy, i, os, st_q[i]);
      end
      ev = exp_vec(st_q[i], ori, rdy_q[i]);
      ov = obs(legacy);
      n_vec++;
      if (ov !== ev) begin
        n_bad++;
        $display("FAIL outputs op=%b legacy=%0d cyc=%0d state=%0d got=%b want=%b", opc, legacy, i, st_q[i], ov, ev);
      end
      orr = legacy ? {29'd0, retired_j} : retired;
      er = legacy ? 32'(exp_ret & 7) : 32'(exp_ret);
      n_vec++;
      if (orr !== er) begin
        n_bad++;
        $display("FAIL retired op=%b legacy=%0d cyc=%0d got=%0d want=%0d", opc, legacy, i, orr, er);
      end
      if (i == abort_at) return;
    end
    if (retire) exp_ret++;
  endtask

  // One extra FETCH cycle with memory not ready: state holds, retired stable.
  task automatic fetch_hold(input bit legacy);
    logic [31:0] orr, er;
    @(negedge clk);
    mem_ready = 1'b0;
    opcode = 6'($urandom);
    #1;
    n_vec++;
    if ((legacy ? state_o_j : state_o) !== 4'd1) begin
      n_bad++;
      $display("FAIL hold_state got=%0d want=1", legacy ? state_o_j : state_o);
    end
    n_vec++;
    if (obs(legacy) !== exp_vec(1, 1'b0, 1'b0)) begin
      n_bad++;
      $display("FAIL hold_outputs got=%b want=%b", obs(legacy), exp_vec(1, 1'b0, 1'b0));
    end
    orr = legacy ? {29'd0, retired_j} : retired;
    er = legacy ? 32'(exp_ret & 7) : 32'(exp_ret);
    n_vec++;
    if (orr !== er) begin
      n_bad++;
      $display("FAIL hold_retired got=%0d want=%0d", orr, er);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    n_vec++;
    if (state_o !== 4'd0 || state_o_j !== 4'd0) begin
      n_bad++;
      $display("FAIL %s_state got=%0d/%0d want=0/0", tag, state_o, state_o_j);
    end
    n_vec++;
    if (obs(1'b0) !== 17'd0 || obs(1'b1) !== 17'd0) begin
      n_bad++;
      $display("FAIL %s_outputs got=%b/%b want=0", tag, obs(1'b0), obs(1'b1));
    end
    n_vec++;
    if (retired !== 32'd0 || retired_j !== 3'd0) begin
      n_bad++;
      $display("FAIL %s_retired got=%0d/%0d want=0", tag, retired, retired_j);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_ret = 0;
    #1;
    check_idle_zero("reset_idle");
  endtask

  task automatic test_reset();
    do_reset();
    run_instr(6'b000000, 0, 0, 1'b0, -1);
    // Abort LW on its second MEMRD wait cycle, then reset between edges.
    run_instr(6'b100011, 0, 3, 1'b0, 4);
    #2;
    mem_ready = 1'b1;
    rst_n = 1'b0;
    exp_ret = 0;
    #1;
    check_idle_zero("async_reset");
    @(negedge clk);
    #1;
    check_idle_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_idle_zero("reset_release");
    run_instr(6'b000000, 0, 0, 1'b0, -1);
  endtask

  task automatic test_rtype();
    run_instr(6'b000000, 0, 0, 1'b0, -1);
    fetch_hold(1'b0);
  endtask

  task automatic test_lw_wait();
    run_instr(6'b100011, 0, 2, 1'b0, -1);
    run_instr(6'b100011, 0, 0, 1'b0, -1);
    fetch_hold(1'b0);
  endtask

  task automatic test_fetch_wait();
    run_instr(6'b000000, 3, 0, 1'b0, -1);
    run_instr(6'b101011, 1, 2, 1'b0, -1);
    run_instr(6'b101011, 0, 0, 1'b0, -1);
  endtask

  task automatic test_ori_beq();
    run_instr(6'b001101, 0, 0, 1'b0, -1);
    run_instr(6'b000100, 0, 0, 1'b0, -1);
    run_instr(6'b001000, 0, 0, 1'b0, -1);
    run_instr(6'b000010, 0, 0, 1'b0, -1);
    fetch_hold(1'b0);
  endtask

  task automatic test_illegal();
    run_instr(6'b111111, 0, 0, 1'b0, -1);
    fetch_hold(1'b0);
    run_instr(6'b010001, 1, 0, 1'b0, -1);
    fetch_hold(1'b0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] opc;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 7))
        0: opc = 6'b000000;
        1: opc = 6'b100011;
        2: opc = 6'b101011;
        3: opc = 6'b000100;
        4: opc = 6'b001000;
        5: opc = 6'b001101;
        6: opc = 6'b000010;
        default: opc = 6'($urandom);
      endcase
      run_instr(opc, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0, -1);
    end
    fetch_hold(1'b0);
  endtask

  // Legacy instance: unknown opcodes act as J and retire; 3-bit counter wraps.
  task automatic test_legacy_wrap();
    do_reset();
    run_instr(6'b111111, 0, 0, 1'b1, -1);
    for (int n = 0; n < 9; n++)
      run_instr(6'($urandom), $urandom_range(0, 1), $urandom_range(0, 2), 1'b1, -1);
    fetch_hold(1'b1);
    n_vec++;
    if (retired_j !== 3'd2) begin
      n_bad++;
      $display("FAIL wrap_retired got=%0d want=2", retired_j);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_fetch_wait();
    test_ori_beq();
    test_illegal();
    test_back_to_back();
    test_legacy_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle successor to the single-cycle MIPS main decoder.
- A Moore FSM sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK over a shared memory port, with a ready handshake for variable-latency memory.
- Adds an illegal-opcode trap mode and a retired-instruction counter.
- Sits between the instruction register and the multi-cycle datapath: register file, ALU, PC and memory muxes.

Parameters:
- OPCODE_W, 6, opcode width (only 6 is legal for MIPS-I decode).
- CNT_W, 32, retired-instruction counter width.
- TRAP_ILLEGAL, 1, 1 = unknown opcode raises illegal and returns to FETCH; 0 = unknown opcode executes as J (legacy behaviour).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPCODE_W  IR[31:26], sampled in DECODE.
- zero  in  1  ALU zero flag (consumed by datapath via pc_write_cond; not used by FSM).
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero (BEQ).
- iord  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  write-back source: 1 = MDR.
- reg_dst  out  1  1 = rd, 0 = rt.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 = B, 01 = 4, 10 = signext imm, 11 = signext imm<<2.
- alu_op  out  2  00 add, 01 sub, 10 funct, 11 or.
- pc_src  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- illegal  out  1  one-cycle pulse on an unknown opcode (TRAP_ILLEGAL=1).
- retired  out  CNT_W  count of completed instructions.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, RTEXE=7, ALUWB=8, BEQ=9, IMMEXE=10, IMMWB=11, JUMP=12, TRAP=13. Codes 14 and 15 go to FETCH next cycle with all outputs 0.
- Reset: rst_n low forces state=IDLE, retired=0 and every output 0, immediately and independent of clk. This includes reset mid-instruction and mid-memory wait.
- IDLE goes to FETCH unconditionally; all outputs 0.
- Outputs are a pure function of state, except ir_write/pc_write in FETCH, which equal mem_ready (Mealy qualification). Any output not listed for a state is 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, ir_write=pc_write=mem_ready. Stay in FETCH while !mem_ready; go to DECODE on mem_ready.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 000000 -> RTEXE
  - 100011 or 101011 -> MEMADR
  - 000100 -> BEQ
  - 001000 or 001101 -> IMMEXE
  - 000010 -> JUMP
  - other -> TRAP if TRAP_ILLEGAL=1, else JUMP.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD: mem_read=1, iord=1. Wait for mem_ready, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
- MEMWR: mem_write=1, iord=1. Wait for mem_ready, then FETCH.
- RTEXE: alu_src_a=1, alu_src_b=00, alu_op=10. Then ALUWB.
- ALUWB: reg_write=1, reg_dst=1. Then FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01. Then FETCH.
- IMMEXE: alu_src_a=1, alu_src_b=10, alu_op=00 (ADDI) or 11 (ORI), from a 1-bit is_ori flag registered in DECODE. Then IMMWB.
- IMMWB: reg_write=1, reg_dst=0. Then FETCH.
- JUMP: pc_write=1, pc_src=10. Then FETCH.
- TRAP: illegal=1 for one cycle, no writes. Then FETCH; retired is not incremented.
- opcode is registered in DECODE into an internal copy used by MEMADR/IMMEXE; later changes on the opcode input are ignored.
- retired increments by 1 on the last-cycle exit of MEMWB, MEMWR (with mem_ready), ALUWB, BEQ, IMMWB and JUMP. It wraps modulo 2^CNT_W, with no saturation.
- Zero-wait latency: BEQ and J 3 cycles; R-type, ADDI, ORI and SW 4 cycles; LW 5 cycles. Each mem_ready-low cycle in FETCH, MEMRD or MEMWR adds 1.
- mem_read and mem_write are never asserted together. pc_write and pc_write_cond are never asserted together.

Test Plan:
- Reset: hold rst_n=0 mid-MEMRD -> state_o=0 and all outputs 0 immediately. Release -> IDLE, then FETCH with mem_read=1.
- R-type: opcode=000000, mem_ready=1 -> states 1,2,7,8,1. ALUWB shows reg_write=1, reg_dst=1. retired goes 0->1.
- LW with 2 wait cycles in MEMRD: opcode=100011 -> states 1,2,3,4,4,4,5. MEMWB shows mem_to_reg=1. Total 7 cycles.
- FETCH wait: mem_ready=0 for 3 cycles -> FETCH held, ir_write=pc_write=0. Both pulse together on the cycle mem_ready=1.
- ORI then BEQ: IMMEXE alu_op=11, then BEQ state with alu_op=01, pc_write_cond=1, pc_src=01. retired advances by 2.
- Illegal opcode 111111: TRAP_ILLEGAL=1 -> state 13, illegal high one cycle, retired unchanged. TRAP_ILLEGAL=0 -> JUMP with pc_write=1, pc_src=10, retired +1.
